// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling blocks.
package rc4_pkg;
    localparam int S_DEPTH       = 256;
    localparam int KEY_BYTES_DEF = 3;
    localparam int MAX_KEY_BYTES = 32;
    localparam int MAX_KEY_W     = 8 * MAX_KEY_BYTES;

    typedef enum logic [3:0] {
        IDLE, READ_I, WAIT_I, CALC_J, READ_J, WAIT_J, WRITE_I, WRITE_J, NEXT, DONE
    } ksa_state_t;

    // Byte k of an nbytes-long key, byte 0 being the most significant.
    function automatic logic [7:0] key_byte(input logic [MAX_KEY_W-1:0] key,
                                            input int nbytes, input int k);
        return key[8*(nbytes-1-k) +: 8];
    endfunction
endpackage

// File: rtl/rc4_key_byte_sel.sv
// Key byte mux: selects byte k of the secret key (byte 0 = MS byte).
// Purely combinational, no flow control.
module rc4_key_byte_sel import rc4_pkg::*; #(
    parameter int KEY_BYTES = KEY_BYTES_DEF,
    parameter int K_W       = 2
) (
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic [K_W-1:0]         k,
    output logic [7:0]             kbyte
);
    logic [MAX_KEY_W-1:0] key_ext;

    always_comb begin
        key_ext                  = '0;
        key_ext[8*KEY_BYTES-1:0] = key;
        kbyte                    = key_byte(key_ext, KEY_BYTES, int'(k));
    end
endmodule

// File: rtl/rc4_ksa_shuffle.sv
// RC4 KSA shuffle over an external S-RAM: 8 cycles per i, finish 2049 cycles after start.
// No backpressure: start is only accepted in IDLE, the RAM is assumed always ready.
module rc4_ksa_shuffle import rc4_pkg::*; #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int KEY_BYTES = KEY_BYTES_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    input  logic [DATA_W-1:0]      mem_q,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_data,
    output logic                   mem_wren,
    output logic                   busy,
    output logic                   finish
);
    localparam int K_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;

    ksa_state_t        state, state_d;
    logic [ADDR_W-1:0] i, i_d, j, j_d, addr_d;
    logic [K_W-1:0]    k, k_d;
    logic [DATA_W-1:0] si, si_d, data_d;
    logic              wren_d, busy_d, finish_d;
    logic [7:0]        kbyte;

    rc4_key_byte_sel #(.KEY_BYTES(KEY_BYTES), .K_W(K_W)) u_key_sel (
        .key   (secret_key),
        .k     (k),
        .kbyte (kbyte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            si       <= '0;
            mem_addr <= '0;
            mem_data <= '0;
            mem_wren <= 1'b0;
            busy     <= 1'b0;
            finish   <= 1'b0;
        end else begin
            state    <= state_d;
            i        <= i_d;
            j        <= j_d;
            k        <= k_d;
            si       <= si_d;
            mem_addr <= addr_d;
            mem_data <= data_d;
            mem_wren <= wren_d;
            busy     <= busy_d;
            finish   <= finish_d;
        end
    end

    // Outputs are registered from the next-state values so they line up with the state they belong to.
    always_comb begin
        state_d  = state;
        i_d      = i;
        j_d      = j;
        k_d      = k;
        si_d     = si;
        addr_d   = mem_addr;
        data_d   = mem_data;
        wren_d   = 1'b0;
        finish_d = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_d = READ_I;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    addr_d  = '0;
                end
            end
            READ_I: state_d = WAIT_I;
            WAIT_I: state_d = CALC_J;
            CALC_J: begin
                si_d    = mem_q;
                j_d     = j + ADDR_W'(mem_q) + ADDR_W'(kbyte);
                addr_d  = j_d;
                state_d = READ_J;
            end
            READ_J: state_d = WAIT_J;
            WAIT_J: begin
                addr_d  = i;
                data_d  = mem_q;
                wren_d  = 1'b1;
                state_d = WRITE_I;
            end
            WRITE_I: begin
                addr_d  = j;
                data_d  = si;
                wren_d  = 1'b1;
                state_d = WRITE_J;
            end
            WRITE_J: state_d = NEXT;
            NEXT: begin
                if (&i) begin
                    finish_d = 1'b1;
                    state_d  = DONE;
                end else begin
                    i_d     = i + 1'b1;
                    k_d     = (k == K_W'(KEY_BYTES-1)) ? '0 : k + 1'b1;
                    addr_d  = i_d;
                    state_d = READ_I;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end
endmodule
